// File: rtl/fu_share_arbiter.sv
// fu_share_arbiter
//   Shares one multi-cycle functional unit (ce/idle/done handshake) among
//   NUM_REQ issue ports. A round-robin arbiter picks one requester, pulses
//   fu_ce with that requester's operands, remembers the owner and its tag, and
//   holds the FU result until writeback takes it. Only one op is in flight.
//
// Ports
//   clk, rst             clock, synchronous active-high reset
//   req_valid/req_ready  per-requester issue handshake (ready is one-hot or zero)
//   req_data0/req_data1  flattened operands, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_tag              flattened destination tags, same packing
//   flush                kills the in-flight op and any held result
//   fu_ce/fu_idle        FU start pulse / FU ready to accept
//   fu_data_0/fu_data_1  operands to the FU (meaningful only while fu_ce=1)
//   fu_result/fu_done    FU result and completion pulse
//   res_valid/res_ready  result handshake towards writeback
//   res_data/res_tag     held result and its destination tag
//   res_src              index of the requester that owns the result
//   timeout_err          sticky watchdog error (only with FU_SHARE_ARB_TIMEOUT_EN)
//
// Optional feature
//   Define FU_SHARE_ARB_TIMEOUT_EN to add a watchdog: an op that waits
//   TIMEOUT_CYCLES cycles without fu_done is dropped and timeout_err is set.

module fu_share_arbiter #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned TAG_WIDTH      = 6,
    parameter int unsigned TIMEOUT_CYCLES = 64,
    localparam int unsigned IdxWidth      = $clog2(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data0,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data1,
    input  logic [NUM_REQ*TAG_WIDTH-1:0]  req_tag,
    input  logic                          flush,
    output logic                          fu_ce,
    input  logic                          fu_idle,
    output logic [DATA_WIDTH-1:0]         fu_data_0,
    output logic [DATA_WIDTH-1:0]         fu_data_1,
    input  logic [DATA_WIDTH-1:0]         fu_result,
    input  logic                          fu_done,
    output logic                          res_valid,
    input  logic                          res_ready,
    output logic [DATA_WIDTH-1:0]         res_data,
    output logic [TAG_WIDTH-1:0]          res_tag,
    output logic [IdxWidth-1:0]           res_src
`ifdef FU_SHARE_ARB_TIMEOUT_EN
    ,
    output logic                          timeout_err
`endif
);

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e state_q, state_d;

    logic [DATA_WIDTH-1:0] op0 [NUM_REQ];
    logic [DATA_WIDTH-1:0] op1 [NUM_REQ];
    logic [TAG_WIDTH-1:0]  tag [NUM_REQ];

    logic [IdxWidth-1:0]   rr_ptr_q;
    logic [IdxWidth-1:0]   cand;
    logic [IdxWidth-1:0]   win_idx;
    logic                  win_found;

    logic                  grant;
    logic                  capture;
    logic                  res_accept;
    logic                  wd_expire;

    logic [TAG_WIDTH-1:0]  owner_tag_q;
    logic                  res_valid_q;
    logic [DATA_WIDTH-1:0] res_data_q;
    logic [TAG_WIDTH-1:0]  res_tag_q;
    logic [IdxWidth-1:0]   res_src_q;

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
        assign op0[gi] = req_data0[gi*DATA_WIDTH +: DATA_WIDTH];
        assign op1[gi] = req_data1[gi*DATA_WIDTH +: DATA_WIDTH];
        assign tag[gi] = req_tag[gi*TAG_WIDTH +: TAG_WIDTH];
    end

    // Round-robin pick: scan from the slot after the last winner, wrapping around.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int unsigned off = 1; off <= NUM_REQ; off++) begin
            cand = IdxWidth'((32'(rr_ptr_q) + off) % NUM_REQ);
            if (!win_found && req_valid[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // ---------------------------------------------------------------------
    // FSM: state register
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------------------------------------------------------------
    // FSM: next state (flush overrides every transition)
    // ---------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: if (grant) state_d = StWait;
                StWait: begin
                    if (fu_done) begin
                        state_d = StResp;
                    end else if (wd_expire) begin
                        state_d = StIdle;
                    end
                end
                StResp: if (res_ready) state_d = StIdle;
                default: state_d = StIdle;
            endcase
        end
    end

    // ---------------------------------------------------------------------
    // FSM: outputs and strobes
    // ---------------------------------------------------------------------
    always_comb begin
        grant      = (state_q == StIdle) && win_found && fu_idle && !flush;
        capture    = (state_q == StWait) && fu_done && !flush;
        res_accept = (state_q == StResp) && res_ready && !flush;
        fu_ce      = grant;
        req_ready  = '0;
        if (grant) begin
            req_ready[win_idx] = 1'b1;
        end
        fu_data_0  = op0[win_idx];
        fu_data_1  = op1[win_idx];
    end

    // ---------------------------------------------------------------------
    // Owner tracking and result holding register
    // ---------------------------------------------------------------------
    // rr_ptr_q only moves on a grant, so while an op is in flight it also
    // names the owner; res_src is taken from it.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q    <= IdxWidth'(NUM_REQ - 1);
            owner_tag_q <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_tag_q   <= '0;
            res_src_q   <= '0;
        end else begin
            if (grant) begin
                rr_ptr_q    <= win_idx;
                owner_tag_q <= tag[win_idx];
            end
            if (flush) begin
                res_valid_q <= 1'b0;
            end else if (capture) begin
                res_valid_q <= 1'b1;
                res_data_q  <= fu_result;
                res_tag_q   <= owner_tag_q;
                res_src_q   <= rr_ptr_q;
            end else if (res_accept) begin
                res_valid_q <= 1'b0;
            end
        end
    end

    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign res_tag   = res_tag_q;
    assign res_src   = res_src_q;

`ifdef FU_SHARE_ARB_TIMEOUT_EN
    localparam int unsigned WdWidth = $clog2(TIMEOUT_CYCLES + 1);

    logic [WdWidth-1:0] wd_cnt_q;
    logic               timeout_err_q;

    // Counter holds the number of completed WAIT cycles; the limit is hit in
    // the TIMEOUT_CYCLES-th WAIT cycle unless fu_done arrives in that cycle.
    assign wd_expire = (state_q == StWait) && !fu_done &&
                       (wd_cnt_q == WdWidth'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            wd_cnt_q      <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            if (grant) begin
                wd_cnt_q <= '0;
            end else if (state_q == StWait) begin
                wd_cnt_q <= wd_cnt_q + 1'b1;
            end
            if (wd_expire && !flush) begin
                timeout_err_q <= 1'b1;
            end
        end
    end

    assign timeout_err = timeout_err_q;
`else
    logic [31:0] unused_timeout_cycles;

    assign wd_expire             = 1'b0;
    assign unused_timeout_cycles = 32'(TIMEOUT_CYCLES);
`endif

endmodule
